mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares one external multiplier datapath between NUM_REQ requesters.
//  It grants one requester at a time and latches that requester's operands onto the multiplier inputs.
//  It waits the multiplier's fixed latency, then returns the product tagged with the requester ID.
//  It sits between requester blocks and the shared multiplier instance. It performs no arithmetic itself.
// PARAMETERS
//  NUM_REQ   4  number of requesters, 2..16
//  A_WIDTH   8  operand A width
//  B_WIDTH   8  operand B width
//  LATENCY   3  cycles from mul_start seen at the multiplier to a valid mul_product, >=0 (0 = combinational)
//  ID_WIDTH  2  width of resp_id; must satisfy 2**ID_WIDTH >= NUM_REQ
// PORTS
//  clk           in   1                  clock; all logic on the rising edge
//  rst_n         in   1                  synchronous active-low reset
//  req           in   NUM_REQ            request vector, one bit per requester
//  req_a         in   NUM_REQ*A_WIDTH    operand A; requester i at [i*A_WIDTH +: A_WIDTH]
//  req_b         in   NUM_REQ*B_WIDTH    operand B; requester i at [i*B_WIDTH +: B_WIDTH]
//  gnt           out  NUM_REQ            one-hot grant; 1-cycle pulse
//  mul_start     out  1                  1-cycle start pulse to the multiplier
//  mul_a         out  A_WIDTH            operand A to the multiplier; held for the whole operation
//  mul_b         out  B_WIDTH            operand B to the multiplier; held for the whole operation
//  mul_product   in   A_WIDTH+B_WIDTH    product from the multiplier
//  resp_valid    out  1                  1-cycle result strobe; no backpressure
//  resp_id       out  ID_WIDTH           index of the requester that owns resp_product
//  resp_product  out  A_WIDTH+B_WIDTH    captured product
//  busy          out  1                  high while an operation is in flight (state BUSY)
// BEHAVIOUR
//  Reset values (rst_n=0 at an edge):
//  - state=IDLE; all outputs 0; cnt=0; round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
//  State machine (2 states), all outputs registered:
//  - IDLE, req==0: hold; gnt, mul_start and resp_valid are 0.
//  - IDLE, req!=0 at cycle t: the winner is the first set bit searching last+1, last+2, ... with wrap modulo NUM_REQ.
//    At the edge ending cycle t:
//    - gnt <= onehot(winner); mul_start <= 1; last <= winner.
//    - mul_a <= req_a slice of winner; mul_b <= req_b slice of winner.
//    - cnt <= LATENCY; state <= BUSY.
//  - BUSY: gnt and mul_start clear after their first cycle (t+1); mul_a and mul_b stay stable.
//    - cnt>0: cnt decrements each cycle.
//    - cnt==0 (cycle t+1+LATENCY): capture mul_product into resp_product and the winner index into resp_id.
//      resp_valid is 1 at cycle t+2+LATENCY; state returns to IDLE in the same cycle.
//  - resp_valid is high for exactly 1 cycle. resp_product and resp_id hold their values until the next capture.
//  - Arbitration resumes at t+2+LATENCY, so the next gnt can occur at t+3+LATENCY.
//    Back-to-back grant spacing is LATENCY+2 cycles.
//  Requester contract and boundary cases:
//  - A requester holds req and its operands until it sees its gnt, and drops req in the cycle after gnt.
//  - req changes while BUSY are ignored; there is no queueing beyond req itself.
//  - Simultaneous requests are resolved by round-robin only, so no requester starves.
//    Worst-case wait is (NUM_REQ-1)*(LATENCY+2)+1 cycles.
//  - Pointer wrap: after a grant to NUM_REQ-1, requester 0 has the highest priority.
//  - Reset mid-operation aborts the operation: no resp_valid, the result is discarded, busy=0, and the pointer returns to NUM_REQ-1.
//  - Product width is A_WIDTH+B_WIDTH and is passed through unmodified; signedness is the multiplier's concern.
//  - Requester indices >= NUM_REQ never appear on resp_id.
// TESTING
//  1. LATENCY=3. req=0001, a0=12, b0=10 at cycle 0.
//     -> cycle 1: gnt=0001, mul_start=1, mul_a=12, mul_b=10.
//     -> cycle 5: resp_valid=1, resp_id=0, resp_product=120. busy=1 in cycles 1-4.
//  2. req=1111 held from reset, each requester dropping req after its gnt.
//     -> gnt order 0,1,2,3 at cycles 1,6,11,16; four resp_valid pulses with matching ids.
//  3. Round-robin wrap: after a grant to 3, present req=1001 -> grant 0; then req=1001 again -> grant 3.
//  4. Extremes: a=255, b=255 -> resp_product=16'hFE01. a=0, b=200 -> resp_product=0.
//  5. Reset mid-operation: rst_n=0 at cycle 3 of a grant.
//     -> no resp_valid and busy=0; then req=0101 -> gnt=0001.
//  6. LATENCY=0 with a combinational multiplier: req at cycle 0 -> gnt at cycle 1, resp_valid at cycle 2, next gnt possible at cycle 3.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Round-robin arbiter and sequencer sharing one external multiplier between
// NUM_REQ requesters. A grant latches the winner's operands onto the multiplier
// inputs, waits the multiplier latency, then returns the product tagged with
// the owner's index. No arithmetic is done here.
module mult_share_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int A_WIDTH  = 8,
   parameter int B_WIDTH  = 8,
   parameter int LATENCY  = 3,
   parameter int ID_WIDTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
   output logic [NUM_REQ-1:0]           gnt,
   output logic                         mul_start,
   output logic [A_WIDTH-1:0]           mul_a,
   output logic [B_WIDTH-1:0]           mul_b,
   input  logic [A_WIDTH+B_WIDTH-1:0]   mul_product,
   output logic                         resp_valid,
   output logic [ID_WIDTH-1:0]          resp_id,
   output logic [A_WIDTH+B_WIDTH-1:0]   resp_product,
   output logic                         busy
);

   localparam int P_WIDTH = A_WIDTH + B_WIDTH;
   // Counter must hold LATENCY; keep at least one bit so LATENCY=0 still elaborates.
   localparam int CNT_W   = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Registered state and outputs
   state_t                state_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [ID_WIDTH-1:0]   last_r;
   logic [NUM_REQ-1:0]    gnt_r;
   logic                  start_r;
   logic [A_WIDTH-1:0]    mul_a_r;
   logic [B_WIDTH-1:0]    mul_b_r;
   logic                  resp_valid_r;
   logic [ID_WIDTH-1:0]   resp_id_r;
   logic [P_WIDTH-1:0]    resp_product_r;
   logic                  busy_r;

   // Next-state values
   state_t                state_s;
   logic [CNT_W-1:0]      cnt_s;
   logic [ID_WIDTH-1:0]   last_s;
   logic [NUM_REQ-1:0]    gnt_s;
   logic                  start_s;
   logic [A_WIDTH-1:0]    mul_a_s;
   logic [B_WIDTH-1:0]    mul_b_s;
   logic                  resp_valid_s;
   logic [ID_WIDTH-1:0]   resp_id_s;
   logic [P_WIDTH-1:0]    resp_product_s;
   logic                  busy_s;

   // Arbitration result
   logic                  found_s;
   logic [ID_WIDTH-1:0]   winner_s;
   logic [NUM_REQ-1:0]    onehot_s;

   // Round-robin search: first set request bit after the last winner, wrapping.
   always_comb begin
      found_s  = 1'b0;
      winner_s = last_r;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int  idx;
         logic hit;
         idx      = (int'(last_r) + k) % NUM_REQ;
         hit      = req[idx] && !found_s;
         winner_s = hit ? ID_WIDTH'(idx) : winner_s;
         found_s  = found_s | hit;
      end
      onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
   end

   // Two-state sequencer: next state and next registered outputs.
   always_comb begin
      state_s        = state_r;
      cnt_s          = cnt_r;
      last_s         = last_r;
      gnt_s          = {NUM_REQ{1'b0}};
      start_s        = 1'b0;
      mul_a_s        = mul_a_r;
      mul_b_s        = mul_b_r;
      resp_valid_s   = 1'b0;
      resp_id_s      = resp_id_r;
      resp_product_s = resp_product_r;
      busy_s         = busy_r;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               gnt_s   = onehot_s;
               start_s = 1'b1;
               last_s  = winner_s;
               mul_a_s = req_a[winner_s*A_WIDTH +: A_WIDTH];
               mul_b_s = req_b[winner_s*B_WIDTH +: B_WIDTH];
               cnt_s   = CNT_W'(LATENCY);
               state_s = BUSY;
               busy_s  = 1'b1;
            end else begin
               busy_s  = 1'b0;
            end
         end
         BUSY: begin
            if (cnt_r != {CNT_W{1'b0}}) begin
               cnt_s  = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
               busy_s = 1'b1;
            end else begin
               // Product is valid this cycle; capture it and release the multiplier.
               resp_product_s = mul_product;
               resp_id_s      = last_r;
               resp_valid_s   = 1'b1;
               state_s        = IDLE;
               busy_s         = 1'b0;
            end
         end
         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         cnt_r          <= {CNT_W{1'b0}};
         last_r         <= ID_WIDTH'(NUM_REQ - 1);
         gnt_r          <= {NUM_REQ{1'b0}};
         start_r        <= 1'b0;
         mul_a_r        <= {A_WIDTH{1'b0}};
         mul_b_r        <= {B_WIDTH{1'b0}};
         resp_valid_r   <= 1'b0;
         resp_id_r      <= {ID_WIDTH{1'b0}};
         resp_product_r <= {P_WIDTH{1'b0}};
         busy_r         <= 1'b0;
      end else begin
         state_r        <= state_s;
         cnt_r          <= cnt_s;
         last_r         <= last_s;
         gnt_r          <= gnt_s;
         start_r        <= start_s;
         mul_a_r        <= mul_a_s;
         mul_b_r        <= mul_b_s;
         resp_valid_r   <= resp_valid_s;
         resp_id_r      <= resp_id_s;
         resp_product_r <= resp_product_s;
         busy_r         <= busy_s;
      end
   end

   assign gnt          = gnt_r;
   assign mul_start    = start_r;
   assign mul_a        = mul_a_r;
   assign mul_b        = mul_b_r;
   assign resp_valid   = resp_valid_r;
   assign resp_id      = resp_id_r;
   assign resp_product = resp_product_r;
   assign busy         = busy_r;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: one LATENCY=3 instance with a
// pipelined multiplier model and one LATENCY=0 instance with a combinational one.
module tb_mult_share_arbiter;

   logic        clk;
   logic        rst_n;

   // LATENCY = 3 instance
   logic [3:0]  req;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  gnt;
   logic        mul_start;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_product;
   logic        resp_valid;
   logic [1:0]  resp_id;
   logic [15:0] resp_product;
   logic        busy;

   // LATENCY = 0 instance
   logic [3:0]  z_req;
   logic [31:0] z_req_a;
   logic [31:0] z_req_b;
   logic [3:0]  z_gnt;
   logic        z_mul_start;
   logic [7:0]  z_mul_a;
   logic [7:0]  z_mul_b;
   logic [15:0] z_mul_product;
   logic        z_resp_valid;
   logic [1:0]  z_resp_id;
   logic [15:0] z_resp_product;
   logic        z_busy;

   int n_assert = 0;
   int n_fail   = 0;

   mult_share_arbiter #(.NUM_REQ(4), .A_WIDTH(8), .B_WIDTH(8), .LATENCY(3), .ID_WIDTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
      .gnt(gnt), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_product(mul_product), .resp_valid(resp_valid), .resp_id(resp_id),
      .resp_product(resp_product), .busy(busy)
   );

   mult_share_arbiter #(.NUM_REQ(4), .A_WIDTH(8), .B_WIDTH(8), .LATENCY(0), .ID_WIDTH(2)) dut_z (
      .clk(clk), .rst_n(rst_n), .req(z_req), .req_a(z_req_a), .req_b(z_req_b),
      .gnt(z_gnt), .mul_start(z_mul_start), .mul_a(z_mul_a), .mul_b(z_mul_b),
      .mul_product(z_mul_product), .resp_valid(z_resp_valid), .resp_id(z_resp_id),
      .resp_product(z_resp_product), .busy(z_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 3-stage multiplier: product valid exactly 3 cycles after mul_start, garbage otherwise.
   logic [15:0] p1, p2, p3;
   logic        v1, v2, v3;
   always @(posedge clk) begin
      v1 <= mul_start;
      p1 <= 16'(mul_a) * 16'(mul_b);
      v2 <= v1;
      p2 <= p1;
      v3 <= v2;
      p3 <= p2;
   end
   assign mul_product   = v3 ? p3 : 16'hDEAD;
   assign z_mul_product = 16'(z_mul_a) * 16'(z_mul_b);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[i*8 +: 8] = a;
      req_b[i*8 +: 8] = b;
   endtask

   // One full operation on the LATENCY=3 instance, starting in the IDLE cycle where req is presented.
   task automatic op(input string tag, input logic [3:0] g, input logic [7:0] ea,
                     input logic [7:0] eb, input logic [15:0] ep, input logic [1:0] eid);
      step();
      check({tag, "_gnt"},   32'(gnt), 32'(g));
      check({tag, "_start"}, 32'(mul_start), 32'd1);
      check({tag, "_mul_a"}, 32'(mul_a), 32'(ea));
      check({tag, "_mul_b"}, 32'(mul_b), 32'(eb));
      check({tag, "_busy1"}, 32'(busy), 32'd1);
      check({tag, "_rv0"},   32'(resp_valid), 32'd0);
      req = req & ~g;
      for (int i = 0; i < 3; i++) begin
         step();
         check({tag, "_gnt_clr"},   32'(gnt), 32'd0);
         check({tag, "_start_clr"}, 32'(mul_start), 32'd0);
         check({tag, "_busy"},      32'(busy), 32'd1);
         check({tag, "_rv_early"},  32'(resp_valid), 32'd0);
         check({tag, "_a_hold"},    32'(mul_a), 32'(ea));
         check({tag, "_b_hold"},    32'(mul_b), 32'(eb));
      end
      step();
      check({tag, "_rv"},   32'(resp_valid), 32'd1);
      check({tag, "_id"},   32'(resp_id), 32'(eid));
      check({tag, "_prod"}, 32'(resp_product), 32'(ep));
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_gnt0"}, 32'(gnt), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      req = 4'b0000; req_a = 32'd0; req_b = 32'd0;
      z_req = 4'b0000; z_req_a = 32'd0; z_req_b = 32'd0;
      repeat (2) step();

      // Reset state
      check("rst_gnt",   32'(gnt), 32'd0);
      check("rst_start", 32'(mul_start), 32'd0);
      check("rst_rv",    32'(resp_valid), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_mul_a", 32'(mul_a), 32'd0);
      check("rst_prod",  32'(resp_product), 32'd0);
      check("rst_z_busy", 32'(z_busy), 32'd0);
      rst_n = 1'b1;

      // Test 1: single request, 12*10
      req = 4'b0001; set_ops(0, 8'd12, 8'd10);
      op("t1", 4'b0001, 8'd12, 8'd10, 16'd120, 2'd0);
      step();
      check("t1_rv_pulse", 32'(resp_valid), 32'd0);
      check("t1_hold",     32'(resp_product), 32'd120);

      // Test 2: all four requesting from reset, served 0,1,2,3 every 5 cycles
      rst_n = 1'b0;
      req = 4'b1111;
      set_ops(0, 8'd3, 8'd10); set_ops(1, 8'd4, 8'd11);
      set_ops(2, 8'd5, 8'd12); set_ops(3, 8'd6, 8'd13);
      step();
      rst_n = 1'b1;
      op("t2_r0", 4'b0001, 8'd3, 8'd10, 16'd30, 2'd0);
      op("t2_r1", 4'b0010, 8'd4, 8'd11, 16'd44, 2'd1);
      op("t2_r2", 4'b0100, 8'd5, 8'd12, 16'd60, 2'd2);
      op("t2_r3", 4'b1000, 8'd6, 8'd13, 16'd78, 2'd3);

      // Test 3: pointer wrap after a grant to 3, then rotation back to 3
      req = 4'b1001; set_ops(0, 8'd9, 8'd9); set_ops(3, 8'd2, 8'd100);
      op("t3_wrap", 4'b0001, 8'd9, 8'd9, 16'd81, 2'd0);
      req = 4'b1001;
      op("t3_rot", 4'b1000, 8'd2, 8'd100, 16'd200, 2'd3);
      req = 4'b0000;

      // Test 4: operand extremes
      req = 4'b0010; set_ops(1, 8'd0, 8'd200);
      op("t4_zero", 4'b0010, 8'd0, 8'd200, 16'd0, 2'd1);
      req = 4'b0100; set_ops(2, 8'd255, 8'd255);
      op("t4_max", 4'b0100, 8'd255, 8'd255, 16'hFE01, 2'd2);
      step();
      check("t4_hold", 32'(resp_product), 32'hFE01);

      // Test 5: reset in cycle 3 of an operation
      req = 4'b0001; set_ops(0, 8'd11, 8'd13);
      step();
      check("t5_gnt", 32'(gnt), 32'b0001);
      req = 4'b0000;
      step();
      step();
      check("t5_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("t5_busy",  32'(busy), 32'd0);
      check("t5_rv",    32'(resp_valid), 32'd0);
      check("t5_mul_a", 32'(mul_a), 32'd0);
      check("t5_prod",  32'(resp_product), 32'd0);
      check("t5_id",    32'(resp_id), 32'd0);
      step();
      check("t5_no_rv1", 32'(resp_valid), 32'd0);
      step();
      check("t5_no_rv2", 32'(resp_valid), 32'd0);
      req = 4'b0101; set_ops(0, 8'd7, 8'd9); set_ops(2, 8'd3, 8'd3);
      op("t5_after", 4'b0001, 8'd7, 8'd9, 16'd63, 2'd0);
      req = 4'b0000;

      // Test 6: LATENCY=0 instance, back-to-back grants 2 cycles apart
      z_req = 4'b0011;
      z_req_a[7:0] = 8'd5; z_req_b[7:0] = 8'd6;
      z_req_a[15:8] = 8'd7; z_req_b[15:8] = 8'd8;
      step();
      check("t6_gnt0",  32'(z_gnt), 32'b0001);
      check("t6_start", 32'(z_mul_start), 32'd1);
      check("t6_busy",  32'(z_busy), 32'd1);
      check("t6_rv0",   32'(z_resp_valid), 32'd0);
      z_req = 4'b0010;
      step();
      check("t6_rv_a",   32'(z_resp_valid), 32'd1);
      check("t6_id_a",   32'(z_resp_id), 32'd0);
      check("t6_prod_a", 32'(z_resp_product), 32'd30);
      check("t6_idle",   32'(z_busy), 32'd0);
      check("t6_gnt_clr", 32'(z_gnt), 32'd0);
      step();
      check("t6_gnt1",  32'(z_gnt), 32'b0010);
      check("t6_mul_a", 32'(z_mul_a), 32'd7);
      check("t6_rv_pulse", 32'(z_resp_valid), 32'd0);
      z_req = 4'b0000;
      step();
      check("t6_rv_b",   32'(z_resp_valid), 32'd1);
      check("t6_id_b",   32'(z_resp_id), 32'd1);
      check("t6_prod_b", 32'(z_resp_product), 32'd56);
      step();
      check("t6_end_rv",  32'(z_resp_valid), 32'd0);
      check("t6_end_gnt", 32'(z_gnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
